// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 7;

    // Rounded clocks-per-oversample-tick, never below 1.
    function automatic int baud_div(input int clkHz, input int baud);
        int divisor;
        divisor = (clkHz + (OVS / 2) * baud) / (OVS * baud);
        return (divisor < 1) ? 1 : divisor;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       headData,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign count    = wrPtr - rdPtr;
    assign headData = mem[rdPtr[AW-1:0]];

    // A push into a full FIFO is dropped even when a pop happens in the same cycle.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; contents are only
    // observable behind a valid pointer pair, and a reset here would block RAM inference.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: rxd synchroniser, 16x oversampling tick, frame FSM,
// and a byte FIFO presented as a valid/ready stream.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          nReset,
    input  logic                          rxd,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    rx_state_t        state;
    rx_state_t        stateNext;
    logic             rxMeta;
    logic             rxS;
    logic [DIV_W-1:0] divCnt;
    logic             tick;
    logic [3:0]       sampleCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             midBit;
    logic             bitEnd;
    logic             clrSample;
    logic             takeBit;
    logic             push;
    logic             frameErrNext;
    logic             overrunNext;
    logic             fifoEmpty;
    logic             fifoFull;

    assign tick   = (divCnt == DIV_W'(DIV - 1));
    assign midBit = tick && (sampleCnt == 4'(MID_SAMPLE));
    assign bitEnd = tick && (sampleCnt == 4'(OVS - 1));

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxS    <= rxMeta;
        end
    end

    // The divider idles at zero so tick phase is locked to the detected start edge.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            divCnt    <= '0;
            sampleCnt <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
        end else begin
            if (state == IDLE || tick) divCnt <= '0;
            else                       divCnt <= divCnt + DIV_W'(1);

            if (state == IDLE || clrSample) sampleCnt <= '0;
            else if (tick)                  sampleCnt <= sampleCnt + 4'd1;

            if (clrSample)    bitIdx <= '0;
            else if (takeBit) bitIdx <= bitIdx + 3'd1;

            if (takeBit) shiftReg <= {rxS, shiftReg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= stateNext;
            frame_err <= frameErrNext;
            overrun   <= overrunNext;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        stateNext    = state;
        clrSample    = 1'b0;
        takeBit      = 1'b0;
        push         = 1'b0;
        frameErrNext = 1'b0;
        overrunNext  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxS) begin
                    stateNext = START;
                    clrSample = 1'b1;
                end
            end
            START: begin
                if (midBit) begin
                    clrSample = 1'b1;
                    stateNext = rxS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    takeBit = 1'b1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end
            end
            STOP: begin
                // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
                if (bitEnd) begin
                    if (rxS) begin
                        if (fifoFull) overrunNext = 1'b1;
                        else          push        = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        frameErrNext = 1'b1;
                        stateNext    = BREAK;
                    end
                end
            end
            BREAK: begin
                if (tick && rxS) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nReset   (nReset),
        .push     (push),
        .pushData (shiftReg),
        .pop      (m_ready),
        .headData (m_data),
        .empty    (fifoEmpty),
        .full     (fifoFull),
        .count    (fifo_count)
    );

    assign m_valid = !fifoEmpty;

endmodule
